// File: rtl/mem_dp_param.sv
// Dual-port word memory: read-only instruction port, byte-enabled read/write data port,
// and a clear engine that zeroes the array after reset or on request.
module mem_dp_param #(
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned ADDR_W         = 8,
    parameter bit          RDW_MODE       = 1'b0,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_rd_en,
    input  logic [ADDR_W-1:0]    i_addr,
    output logic [DATA_W-1:0]    i_rdata,
    output logic                 i_valid,
    input  logic                 d_rd_en,
    input  logic                 memwrite,
    input  logic [ADDR_W-1:0]    d_addr,
    input  logic [DATA_W/8-1:0]  d_be,
    input  logic [DATA_W-1:0]    d_wdata,
    output logic [DATA_W-1:0]    d_rdata,
    output logic                 d_valid,
    input  logic                 clr_req,
    output logic                 busy,
    output logic                 err
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned BE_W  = DATA_W / 8;

    typedef enum logic [0:0] {StIdle, StClear} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   clr_ptr_q, clr_ptr_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                i_valid_q, i_valid_d;
    logic                d_valid_q, d_valid_d;
    logic                err_q, err_d;

    logic                clr_we;
    logic                i_rd_acc, d_rd_acc, d_wr_acc;
    logic [DATA_W-1:0]   d_old, d_merged, bit_mask;

    // Clear engine: one word per cycle, returns to idle after the top word
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        clr_we    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (clr_req) begin
                    state_d = StClear;
                end
            end
            StClear: begin
                clr_we    = 1'b1;
                clr_ptr_d = clr_ptr_q + 1'b1;
                if (clr_ptr_q == '1) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy     = (state_q == StClear);
    assign i_rd_acc = i_rd_en  && !busy;
    assign d_rd_acc = d_rd_en  && !busy;
    assign d_wr_acc = memwrite && !busy;

    always_comb begin
        bit_mask = '0;
        for (int unsigned k = 0; k < BE_W; k++) begin
            bit_mask[8*k +: 8] = {8{d_be[k]}};
        end
    end

    assign d_old    = mem_q[d_addr];
    assign d_merged = (d_wdata & bit_mask) | (d_old & ~bit_mask);

    always_comb begin
        i_valid_d = i_rd_acc;
        d_valid_d = d_rd_acc;
        err_d     = busy && (i_rd_en || d_rd_en || memwrite);
        i_rdata_d = i_rd_acc ? mem_q[i_addr] : i_rdata_q;
        d_rdata_d = d_rdata_q;
        if (d_rd_acc) begin
            d_rdata_d = (RDW_MODE && d_wr_acc) ? d_merged : d_old;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= CLEAR_ON_RESET ? StClear : StIdle;
            clr_ptr_q <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            i_valid_q <= 1'b0;
            d_valid_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            i_valid_q <= i_valid_d;
            d_valid_q <= d_valid_d;
            err_q     <= err_d;
        end
    end

    // Array has no reset; writes are suppressed on reset edges so reset never alters contents
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (clr_we) begin
                mem_q[clr_ptr_q] <= '0;
            end else if (d_wr_acc) begin
                for (int unsigned k = 0; k < BE_W; k++) begin
                    if (d_be[k]) begin
                        mem_q[d_addr][8*k +: 8] <= d_wdata[8*k +: 8];
                    end
                end
            end
        end
    end

    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;
    assign i_valid = i_valid_q;
    assign d_valid = d_valid_q;
    assign err     = err_q;

endmodule

// File: tb/tb_mem_dp_param.sv
// Scoreboard bench for mem_dp_param: two 32-bit instances (old-data and write-first RDW)
// share stimulus; a negedge monitor pops expected read data whenever a valid appears.
module tb_mem_dp_param;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int BW = DW / 8;

    logic          clk = 1'b0;
    logic          rst_n, i_rd_en, d_rd_en, memwrite, clr_req;
    logic [AW-1:0] i_addr, d_addr;
    logic [BW-1:0] d_be;
    logic [DW-1:0] d_wdata;

    logic [DW-1:0] i_rdata0, d_rdata0, i_rdata1, d_rdata1;
    logic          i_valid0, d_valid0, busy0, err0;
    logic          i_valid1, d_valid1, busy1, err1;

    logic [DW-1:0] exp_i0[$], exp_d0[$], exp_i1[$], exp_d1[$];
    int n_checks = 0;
    int n_pass   = 0;
    int n;

    always #5 clk = ~clk;

    mem_dp_param #(.DATA_W(DW), .ADDR_W(AW), .RDW_MODE(1'b0), .CLEAR_ON_RESET(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .i_rd_en(i_rd_en), .i_addr(i_addr), .i_rdata(i_rdata0),
        .i_valid(i_valid0), .d_rd_en(d_rd_en), .memwrite(memwrite), .d_addr(d_addr),
        .d_be(d_be), .d_wdata(d_wdata), .d_rdata(d_rdata0), .d_valid(d_valid0),
        .clr_req(clr_req), .busy(busy0), .err(err0)
    );

    mem_dp_param #(.DATA_W(DW), .ADDR_W(AW), .RDW_MODE(1'b1), .CLEAR_ON_RESET(1'b1)) dut_wf (
        .clk(clk), .rst_n(rst_n), .i_rd_en(i_rd_en), .i_addr(i_addr), .i_rdata(i_rdata1),
        .i_valid(i_valid1), .d_rd_en(d_rd_en), .memwrite(memwrite), .d_addr(d_addr),
        .d_be(d_be), .d_wdata(d_wdata), .d_rdata(d_rdata1), .d_valid(d_valid1),
        .clr_req(clr_req), .busy(busy1), .err(err1)
    );

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endtask

    task automatic unexpected(input string name);
        n_checks++;
        $display("FAIL %s: valid got 1 with no read pending, required 0", name);
    endtask

    always @(negedge clk) begin
        if (i_valid0) begin
            if (exp_i0.size() == 0) unexpected("i_valid rdw0");
            else check("i_rdata rdw0", i_rdata0, exp_i0.pop_front());
        end
        if (d_valid0) begin
            if (exp_d0.size() == 0) unexpected("d_valid rdw0");
            else check("d_rdata rdw0", d_rdata0, exp_d0.pop_front());
        end
        if (i_valid1) begin
            if (exp_i1.size() == 0) unexpected("i_valid rdw1");
            else check("i_rdata rdw1", i_rdata1, exp_i1.pop_front());
        end
        if (d_valid1) begin
            if (exp_d1.size() == 0) unexpected("d_valid rdw1");
            else check("d_rdata rdw1", d_rdata1, exp_d1.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_rd_en  = 1'b0;
        d_rd_en  = 1'b0;
        memwrite = 1'b0;
        clr_req  = 1'b0;
        i_addr   = '0;
        d_addr   = '0;
        d_be     = '0;
        d_wdata  = '0;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [BW-1:0] be, input logic [DW-1:0] dat);
        d_addr = a; d_be = be; d_wdata = dat; memwrite = 1'b1;
        tick();
        memwrite = 1'b0;
    endtask

    task automatic rd_d(input logic [AW-1:0] a, input logic [DW-1:0] exp);
        d_addr = a; d_rd_en = 1'b1;
        exp_d0.push_back(exp);
        exp_d1.push_back(exp);
        tick();
        d_rd_en = 1'b0;
    endtask

    task automatic rd_i(input logic [AW-1:0] a, input logic [DW-1:0] exp);
        i_addr = a; i_rd_en = 1'b1;
        exp_i0.push_back(exp);
        exp_i1.push_back(exp);
        tick();
        i_rd_en = 1'b0;
    endtask

    // Same-cycle D write + D read + I read at one address
    task automatic rdw(input logic [AW-1:0] a, input logic [BW-1:0] be, input logic [DW-1:0] dat,
                       input logic [DW-1:0] exp_old, input logic [DW-1:0] exp_new);
        d_addr = a; i_addr = a; d_be = be; d_wdata = dat;
        memwrite = 1'b1; d_rd_en = 1'b1; i_rd_en = 1'b1;
        exp_d0.push_back(exp_old);
        exp_d1.push_back(exp_new);
        exp_i0.push_back(exp_old);
        exp_i1.push_back(exp_old);
        tick();
        memwrite = 1'b0; d_rd_en = 1'b0; i_rd_en = 1'b0;
    endtask

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        return {a, ~a, a ^ 8'h3C, 8'h01};
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, required $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        tick();
        tick();
        check("reset i_valid", i_valid0, 0);
        check("reset d_valid", d_valid0, 0);
        check("reset err", err0, 0);
        check("reset i_rdata", i_rdata0, 0);
        check("reset d_rdata", d_rdata0, 0);
        check("reset busy", busy0, 1);

        // Clear after reset lasts exactly DEPTH cycles
        rst_n = 1'b1;
        n = 0;
        while (busy0 && n < 1000) begin n++; tick(); end
        check("reset clear cycles", n, 256);
        check("reset clear busy wf", busy1, 0);
        rd_d(8'h00, 32'h0);
        rd_i(8'hFF, 32'h0);
        rd_d(8'hFF, 32'h0);

        // Byte-enable merge
        wr(8'd5, 4'b1111, 32'hAABBCCDD);
        wr(8'd5, 4'b0101, 32'h11223344);
        rd_d(8'd5, 32'hAA22CC44);
        wr(8'd5, 4'b0000, 32'hFFFFFFFF);
        rd_i(8'd5, 32'hAA22CC44);

        // Read-during-write, full and partial byte enables
        wr(8'd3, 4'b1111, 32'h11111111);
        rdw(8'd3, 4'b1111, 32'h5A5A5A5A, 32'h11111111, 32'h5A5A5A5A);
        rdw(8'd3, 4'b0001, 32'h000000C3, 32'h5A5A5A5A, 32'h5A5A5AC3);
        rd_d(8'd3, 32'h5A5A5AC3);

        // Fill, then requested clear with busy-time requests
        for (int a = 0; a < 256; a++) wr(8'(a), 4'hF, pat(8'(a)));
        rd_d(8'd9, pat(8'd9));
        rd_i(8'd200, pat(8'd200));
        clr_req = 1'b1;
        tick();
        n = 0;
        while (busy0 && n < 1000) begin
            idle_inputs();
            if (n == 50) clr_req = 1'b1;
            if (n == 60) begin
                memwrite = 1'b1; d_addr = 8'd7; d_be = 4'hF; d_wdata = 32'hDEADBEEF;
            end
            if (n == 61) check("err after busy write", err0, 1);
            if (n == 62) check("err single pulse", err0, 0);
            if (n == 70) begin
                i_rd_en = 1'b1; d_rd_en = 1'b1; i_addr = 8'd7; d_addr = 8'd7;
            end
            if (n == 71) check("err after busy reads", err1, 1);
            n++;
            tick();
        end
        idle_inputs();
        check("clr_req clear cycles", n, 256);
        rd_d(8'd7, 32'h0);
        rd_i(8'd7, 32'h0);
        rd_d(8'd9, 32'h0);
        rd_i(8'd255, 32'h0);
        rd_d(8'd128, 32'h0);

        // Reset at clear step 100 restarts a full clear
        wr(8'd200, 4'hF, 32'hCAFEF00D);
        rd_d(8'd200, 32'hCAFEF00D);
        rd_i(8'd200, 32'hCAFEF00D);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        n = 0;
        while (n < 100) begin n++; tick(); end
        rst_n = 1'b0;
        i_rd_en = 1'b1;
        tick();
        check("midclear reset d_rdata", d_rdata0, 0);
        check("midclear reset i_rdata", i_rdata0, 0);
        check("midclear reset err", err0, 0);
        check("midclear reset busy", busy0, 1);
        rst_n = 1'b1;
        i_rd_en = 1'b0;
        n = 0;
        while (busy0 && n < 1000) begin n++; tick(); end
        check("restarted clear cycles", n, 256);
        rd_d(8'd200, 32'h0);
        rd_d(8'd50, 32'h0);
        rd_i(8'd255, 32'h0);

        tick();
        tick();
        check("pending reads", exp_i0.size() + exp_d0.size() + exp_i1.size() + exp_d1.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
